// File: rtl/minmax_pkg.sv
// rtl/minmax_pkg.sv - shared constants, FSM state and compare-node type for minmax_stream
package minmax_pkg;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    // Node fields are sized for the largest supported configuration
    // (W <= 32, IDXW <= 16, BEATW <= 16); narrower builds leave the upper
    // bits constant zero so unsigned compares are unaffected.
    localparam int NODE_VW = 32;
    localparam int NODE_IW = 16;
    localparam int NODE_BW = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic [NODE_VW-1:0] value;
        logic [NODE_IW-1:0] lane;
        logic [NODE_BW-1:0] beat;
        logic               masked;
    } node_t;

    // Number of entries alive at a given tree level (level 0 = raw lanes).
    function automatic int level_count(input int n, input int level);
        return (n + (1 << level) - 1) >> level;
    endfunction

endpackage

// File: rtl/minmax_cmp_node.sv
// rtl/minmax_cmp_node.sv - two-input masked min/max select with tie-break toward input a
// Ports: mode (0 = min, 1 = max), a/b candidate nodes, y selected node.
// Input a must be the lower lane / earlier beat; b wins only when strictly better.
module minmax_cmp_node
    import minmax_pkg::*;
(
    input  logic  mode,
    input  node_t a,
    input  node_t b,
    output node_t y
);

    logic b_better;

    always_comb begin
        if (mode == MODE_MAX) begin
            b_better = (b.value > a.value);
        end else begin
            b_better = (b.value < a.value);
        end
        // A masked a yields b, which is itself masked when both are masked.
        if (a.masked) begin
            y = b;
        end else if (!b.masked && b_better) begin
            y = b;
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/minmax_stream.sv
// rtl/minmax_stream.sv - pipelined per-frame min/max search over multi-lane beats
// Ports: clk, rst_n (sync, active low); in_valid/in_ready/in_data/in_mask/in_last/mode
// beat input; out_valid/out_ready/out_value/out_lane/out_beat/out_empty frame result.
// Optional macro MINMAX_STREAM_INDEX_EN: track winning lane and beat indices;
// without it out_lane and out_beat are tied to 0.
module minmax_stream
    import minmax_pkg::*;
#(
    parameter int W     = 8,
    parameter int NI    = 16,
    parameter int IDXW  = $clog2(NI),
    parameter int BEATW = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data [NI],
    input  logic [NI-1:0]    in_mask,
    input  logic             in_last,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_value,
    output logic [IDXW-1:0]  out_lane,
    output logic [BEATW-1:0] out_beat,
    output logic             out_empty
);

    localparam int D = $clog2(NI);

    logic advance;
    logic accept;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    // The tree needs the frame mode on every beat, so the first beat's mode
    // is captured at the input and reused for the rest of the frame.
    logic in_first;
    logic mode_lat;
    logic beat_mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_first <= 1'b1;
            mode_lat <= MODE_MIN;
        end else if (accept) begin
            in_first <= in_last;
            if (in_first) begin
                mode_lat <= mode;
            end
        end
    end

    assign beat_mode = in_first ? mode : mode_lat;

    // Compare tree: level 0 is the raw lanes, levels 1..D are registered.
    for (genvar l = 0; l <= D; l++) begin : g_lvl
        localparam int N = level_count(NI, l);
        node_t nd [N];
        logic  vld;
        logic  last;
        logic  md;

        if (l == 0) begin : g_leaf
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    nd[i]        = '0;
                    nd[i].value  = NODE_VW'(in_data[i]);
`ifdef MINMAX_STREAM_INDEX_EN
                    nd[i].lane   = NODE_IW'(i);
`endif
                    nd[i].masked = !in_mask[i];
                end
            end
            assign vld  = accept;
            assign last = in_last;
            assign md   = beat_mode;
        end else begin : g_stage
            localparam int NP = level_count(NI, l - 1);
            node_t nx [N];

            for (genvar j = 0; j < N; j++) begin : g_node
                if (2 * j + 1 < NP) begin : g_pair
                    minmax_cmp_node u_cmp (
                        .mode (g_lvl[l-1].md),
                        .a    (g_lvl[l-1].nd[2*j]),
                        .b    (g_lvl[l-1].nd[2*j+1]),
                        .y    (nx[j])
                    );
                end else begin : g_pass
                    // Unpaired entry at an odd-sized level moves up untouched.
                    assign nx[j] = g_lvl[l-1].nd[2*j];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld <= 1'b0;
                end else if (advance) begin
                    vld <= g_lvl[l-1].vld;
                end
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    nd   <= nx;
                    last <= g_lvl[l-1].last;
                    md   <= g_lvl[l-1].md;
                end
            end
        end
    end

    // Frame accumulator
    node_t      fin;
    logic       fin_vld;
    logic       fin_last;
    logic       fin_md;
    logic       take;
    node_t      held;
    node_t      incoming;
    node_t      combined;
    node_t      result;
    logic       acc_mode;
    acc_state_t state;
    acc_state_t state_nxt;

    assign fin      = g_lvl[D].nd[0];
    assign fin_vld  = g_lvl[D].vld;
    assign fin_last = g_lvl[D].last;
    assign fin_md   = g_lvl[D].md;
    assign take     = advance && fin_vld;

`ifdef MINMAX_STREAM_INDEX_EN
    logic [BEATW-1:0] beat_cnt;
    logic [BEATW-1:0] beat_nxt;

    assign beat_nxt = (beat_cnt == '1) ? beat_cnt : beat_cnt + BEATW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (take) begin
            beat_cnt <= (state == IDLE) ? '0 : beat_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take && !fin_last) state_nxt = ACCUM;
            ACCUM:   if (take && fin_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Held result is input a, so an equal incoming beat never displaces it.
    minmax_cmp_node u_acc_cmp (
        .mode (acc_mode),
        .a    (held),
        .b    (incoming),
        .y    (combined)
    );

    always_comb begin
        incoming = fin;
`ifdef MINMAX_STREAM_INDEX_EN
        incoming.beat = (state == IDLE) ? '0 : NODE_BW'(beat_nxt);
`endif
        result = (state == IDLE) ? incoming : combined;
    end

    always_ff @(posedge clk) begin
        if (take) begin
            held <= result;
            if (state == IDLE) begin
                acc_mode <= fin_md;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_value <= '0;
            out_empty <= 1'b0;
        end else if (advance) begin
            out_valid <= take && fin_last;
            if (take && fin_last) begin
                out_empty <= result.masked;
                out_value <= result.masked ? '0 : result.value[W-1:0];
            end
        end
    end

`ifdef MINMAX_STREAM_INDEX_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_lane <= '0;
            out_beat <= '0;
        end else if (advance && take && fin_last) begin
            out_lane <= result.masked ? '0 : result.lane[IDXW-1:0];
            out_beat <= result.masked ? '0 : result.beat[BEATW-1:0];
        end
    end
`else
    assign out_lane = '0;
    assign out_beat = '0;
`endif

endmodule

// File: tb/tb_minmax_stream.sv
// tb/tb_minmax_stream.sv - self-checking bench for minmax_stream (NI=16 and NI=5 instances)
module tb_minmax_stream;

    localparam int W   = 8;
    localparam int NA  = 16;
    localparam int NB  = 5;
    localparam int BWA = 8;
    localparam int BWB = 2;
`ifdef MINMAX_STREAM_INDEX_EN
    localparam bit IDX = 1'b1;
`else
    localparam bit IDX = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] value;
        logic [3:0] lane;
        logic [7:0] beat;
        logic       empty;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic           a_in_valid, a_in_ready, a_in_last, a_mode;
    logic [W-1:0]   a_in_data [NA];
    logic [NA-1:0]  a_in_mask;
    logic           a_out_valid, a_out_ready, a_out_empty;
    logic [W-1:0]   a_out_value;
    logic [3:0]     a_out_lane;
    logic [BWA-1:0] a_out_beat;

    logic           b_in_valid, b_in_ready, b_in_last, b_mode;
    logic [W-1:0]   b_in_data [NB];
    logic [NB-1:0]  b_in_mask;
    logic           b_out_valid, b_out_ready, b_out_empty;
    logic [W-1:0]   b_out_value;
    logic [2:0]     b_out_lane;
    logic [BWB-1:0] b_out_beat;

    minmax_stream #(.W(W), .NI(NA), .BEATW(BWA)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_mask(a_in_mask), .in_last(a_in_last), .mode(a_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_value(a_out_value),
        .out_lane(a_out_lane), .out_beat(a_out_beat), .out_empty(a_out_empty)
    );

    minmax_stream #(.W(W), .NI(NB), .BEATW(BWB)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_mask(b_in_mask), .in_last(b_in_last), .mode(b_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_value(b_out_value),
        .out_lane(b_out_lane), .out_beat(b_out_beat), .out_empty(b_out_empty)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [W-1:0]  fr_data [8][NA];
    logic [NA-1:0] fr_mask [8];
    int            fr_len;
    logic          fr_mode;
    res_t          exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scan every lane of every beat in arrival order; only a strictly better
    // candidate replaces the current best, giving lowest lane / earliest beat on ties.
    function automatic res_t model(input int ni, input int beat_max);
        res_t r;
        bit   found;
        r = '0;
        found = 1'b0;
        for (int b = 0; b < fr_len; b++) begin
            for (int i = 0; i < ni; i++) begin
                if (fr_mask[b][i] && (!found ||
                    (fr_mode ? (fr_data[b][i] > r.value) : (fr_data[b][i] < r.value)))) begin
                    found   = 1'b1;
                    r.value = fr_data[b][i];
                    r.lane  = i[3:0];
                    r.beat  = (b > beat_max) ? beat_max[7:0] : b[7:0];
                end
            end
        end
        r.empty = !found;
        if (!IDX) begin
            r.lane = '0;
            r.beat = '0;
        end
        return r;
    endfunction

    task automatic rand_frame(input int len);
        fr_len  = len;
        fr_mode = 1'($urandom_range(0, 1));
        for (int b = 0; b < len; b++) begin
            for (int i = 0; i < NA; i++) begin
                fr_data[b][i] = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 31)) : W'($urandom);
            end
            fr_mask[b] = ($urandom_range(0, 5) == 0) ? '0 : NA'($urandom);
        end
    endtask

    task automatic drive_a(input int gap_max);
        int cyc;
        for (int b = 0; b < fr_len; b++) begin
            for (int g = $urandom_range(0, gap_max); g > 0; g--) begin
                a_in_valid = 1'b0;
                @(posedge clk); #1;
            end
            a_in_valid = 1'b1;
            a_in_data  = fr_data[b];
            a_in_mask  = fr_mask[b];
            a_in_last  = (b == fr_len - 1);
            a_mode     = (b == 0) ? fr_mode : 1'($urandom_range(0, 1));
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!a_in_ready && cyc < 100);
            if (!a_in_ready) check("a.in_ready_timeout", 32'(a_in_ready), 32'd1);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
    endtask

    task automatic check_a(input string tag, input res_t e);
        check({tag, ".valid"}, 32'(a_out_valid), 32'd1);
        check({tag, ".value"}, 32'(a_out_value), 32'(e.value));
        check({tag, ".lane"},  32'(a_out_lane),  32'(e.lane));
        check({tag, ".beat"},  32'(a_out_beat),  32'(e.beat));
        check({tag, ".empty"}, 32'(a_out_empty), 32'(e.empty));
    endtask

    task automatic collect_a(input int n, input int stall);
        int   got;
        int   cyc;
        res_t e;
        got = 0;
        cyc = 0;
        a_out_ready = (stall == 0);
        if (stall > 0) begin
            do begin
                @(negedge clk);
                cyc++;
            end while (!a_out_valid && cyc < 500);
            for (int s = 0; s < stall; s++) begin
                check("stall.in_ready", 32'(a_in_ready), 32'd0);
                check_a("stall.hold", exp_q[0]);
                @(negedge clk);
            end
            @(posedge clk); #1;
            a_out_ready = 1'b1;
        end
        while (got < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (a_out_valid) begin
                if (exp_q.size() == 0) begin
                    check("a.extra_result", 32'(a_out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_a("a.frame", e);
                end
                got++;
            end
        end
        if (got < n) check("a.collect_timeout", 32'(got), 32'(n));
    endtask

    task automatic one_frame_a();
        exp_q.push_back(model(NA, 255));
        fork
            drive_a(0);
            collect_a(1, 0);
        join
        @(posedge clk); #1;
    endtask

    task automatic batch_a(input int nfr, input int maxlen, input int gap, input int stall, input bit chk_rate);
        int     beats;
        longint t0;
        longint t1;
        beats = 0;
        t0 = $time;
        t1 = t0;
        fork
            begin
                for (int k = 0; k < nfr; k++) begin
                    rand_frame($urandom_range(1, maxlen));
                    beats += fr_len;
                    exp_q.push_back(model(NA, 255));
                    drive_a(gap);
                end
                t1 = $time;
            end
            collect_a(nfr, stall);
        join
        if (chk_rate) check("throughput.cycles", 32'((t1 - t0) / 10), 32'(beats));
        @(posedge clk); #1;
    endtask

    task automatic frame_b(input string tag);
        res_t e;
        int   cyc;
        e = model(NB, (1 << BWB) - 1);
        for (int b = 0; b < fr_len; b++) begin
            b_in_valid = 1'b1;
            for (int i = 0; i < NB; i++) b_in_data[i] = fr_data[b][i];
            b_in_mask = fr_mask[b][NB-1:0];
            b_in_last = (b == fr_len - 1);
            b_mode    = (b == 0) ? fr_mode : 1'($urandom_range(0, 1));
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!b_in_ready && cyc < 100);
            if (!b_in_ready) check({tag, ".in_ready_timeout"}, 32'(b_in_ready), 32'd1);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!b_out_valid && cyc < 50);
        check({tag, ".valid"}, 32'(b_out_valid), 32'd1);
        check({tag, ".value"}, 32'(b_out_value), 32'(e.value));
        check({tag, ".lane"},  32'(b_out_lane),  32'(e.lane));
        check({tag, ".beat"},  32'(b_out_beat),  32'(e.beat));
        check({tag, ".empty"}, 32'(b_out_empty), 32'(e.empty));
        @(posedge clk); #1;
    endtask

    initial begin
        res_t e;
        int   lat;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_last = 1'b0; a_mode = 1'b0; a_in_mask = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_last = 1'b0; b_mode = 1'b0; b_in_mask = '0; b_out_ready = 1'b1;
        for (int i = 0; i < NA; i++) a_in_data[i] = '0;
        for (int i = 0; i < NB; i++) b_in_data[i] = '0;

        // Reset state, with out_ready low so in_ready depends on out_valid being cleared
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset.in_ready",  32'(a_in_ready),  32'd1);
        check("reset.out_valid", 32'(a_out_valid), 32'd0);
        check("reset.out_value", 32'(a_out_value), 32'd0);
        check("reset.out_lane",  32'(a_out_lane),  32'd0);
        check("reset.out_beat",  32'(a_out_beat),  32'd0);
        check("reset.out_empty", 32'(a_out_empty), 32'd0);
        check("reset.b_valid",   32'(b_out_valid), 32'd0);
        @(posedge clk); #1;
        a_out_ready = 1'b1;

        // Single-beat min frame with latency measurement
        fr_len = 1; fr_mode = 1'b0; fr_mask[0] = '1;
        for (int i = 0; i < NA; i++) fr_data[0][i] = W'(20 + 10 * i);
        fr_data[0][0] = 8'd9; fr_data[0][1] = 8'd3; fr_data[0][2] = 8'd7;
        fr_data[0][3] = 8'd3; fr_data[0][15] = 8'd255;
        e = model(NA, 255);
        a_in_valid = 1'b1; a_in_data = fr_data[0]; a_in_mask = fr_mask[0];
        a_in_last = 1'b1; a_mode = 1'b0;
        @(negedge clk);
        check("lat.in_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!a_out_valid && lat < 20);
        check("lat.cycles", 32'(lat), 32'd5);
        check_a("lat.frame", e);
        @(posedge clk); #1;

        // Three-beat max frame with a later equal maximum
        fr_len = 3; fr_mode = 1'b1;
        for (int b = 0; b < 3; b++) begin
            fr_mask[b] = '1;
            for (int i = 0; i < NA; i++) fr_data[b][i] = W'(i);
        end
        fr_data[0][2] = 8'd40; fr_data[1][5] = 8'd200; fr_data[2][0] = 8'd200;
        one_frame_a();

        // Fully masked two-beat frame
        rand_frame(2);
        fr_mask[0] = '0; fr_mask[1] = '0;
        one_frame_a();

        // Random back-to-back frames, then frames with bubbles
        batch_a(20, 4, 0, 0, 1'b1);
        batch_a(15, 4, 2, 0, 1'b0);

        // Backpressure with the pipe full
        batch_a(8, 3, 0, 10, 1'b0);

        // Reset in the middle of a frame
        a_in_valid = 1'b1; a_in_last = 1'b0; a_mode = 1'b0; a_in_mask = '1;
        for (int i = 0; i < NA; i++) a_in_data[i] = 8'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset.in_ready",  32'(a_in_ready),  32'd1);
        check("midreset.out_valid", 32'(a_out_valid), 32'd0);
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        fr_len = 1; fr_mode = 1'b0; fr_mask[0] = '1;
        for (int i = 0; i < NA; i++) fr_data[0][i] = 8'd100;
        fr_data[0][6] = 8'd4;
        one_frame_a();

        // Odd-width instance
        fr_len = 1; fr_mode = 1'b0; fr_mask[0] = '1;
        fr_data[0][0] = 8'd8; fr_data[0][1] = 8'd8; fr_data[0][2] = 8'd8;
        fr_data[0][3] = 8'd8; fr_data[0][4] = 8'd1;
        frame_b("b.passthru");

        fr_len = 1; fr_mode = 1'b1; fr_mask[0] = 16'h001e;
        for (int i = 0; i < NB; i++) fr_data[0][i] = 8'd8;
        frame_b("b.masktie");

        fr_len = 6; fr_mode = 1'b1;
        for (int b = 0; b < 6; b++) begin
            fr_mask[b] = '1;
            for (int i = 0; i < NB; i++) fr_data[b][i] = W'(10 * b + i);
        end
        frame_b("b.beatsat");

        for (int k = 0; k < 10; k++) begin
            rand_frame($urandom_range(1, 6));
            frame_b("b.rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
